win_scan_ctrl: RTL and testbench

Sequencer that decides, after every accepted token placement, whether the placing player has connected `WIN_LEN` cells. It walks outward from the placed cell through the shared board-memory read port, one cell per probe, in four directions, and reports `win` with a one-cycle `done` pulse. It sits between the turn FSM, which issues `start` once per successful placement, and the 42-cell board store. It drives the `win` input that moves the turn FSM to game-over.

---
 rtl/c4_pkg.sv | 26 ++
 rtl/win_scan_addr.sv | 23 ++
 rtl/win_scan_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_win_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/c4_pkg.sv
// Shared board constants, cell codes, scan FSM states and direction deltas
// for the connect-four win scanner.
package c4_pkg;

    localparam int unsigned C4_ROWS    = 6;
    localparam int unsigned C4_COLS    = 7;
    localparam int unsigned C4_WIN_LEN = 4;
    localparam int unsigned C4_CELL_W  = 2;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StDir,
        StRead,
        StCmp,
        StDone
    } state_e;

    // Direction d: (drow, dcol) = (0,+1), (+1,0), (+1,+1), (+1,-1)
    localparam logic signed [3:0] DIR_DR [4] = '{4'sd0, 4'sd1, 4'sd1, 4'sd1};
    localparam logic signed [3:0] DIR_DC [4] = '{4'sd1, 4'sd0, 4'sd1, -4'sd1};

endpackage

// File: rtl/win_scan_addr.sv
// Maps a signed (row, col) board coordinate to its in-bounds flag and the
// linear board index row*COLS+col.
module win_scan_addr #(
    parameter int unsigned ROWS = 6,
    parameter int unsigned COLS = 7
) (
    input  logic signed [3:0] r,
    input  logic signed [3:0] c,
    output logic              in_bounds,
    output logic [5:0]        addr
);

    localparam logic [3:0] ROWS4 = 4'(ROWS);
    localparam logic [3:0] COLS4 = 4'(COLS);
    localparam logic [5:0] COLS6 = 6'(COLS);

    always_comb begin
        in_bounds = !r[3] && !c[3] && ($unsigned(r) < ROWS4) && ($unsigned(c) < COLS4);
        // Index is meaningless when out of bounds; callers gate on in_bounds.
        addr      = {2'b00, r} * COLS6 + {2'b00, c};
    end

endmodule

// File: rtl/win_scan_ctrl.sv
// Post-placement win scanner: probes the board outward from the placed cell in
// four directions. Optional draw detection is enabled by WIN_SCAN_DRAW_EN.
module win_scan_ctrl
    import c4_pkg::*;
#(
    parameter int unsigned ROWS    = c4_pkg::C4_ROWS,
    parameter int unsigned COLS    = c4_pkg::C4_COLS,
    parameter int unsigned WIN_LEN = c4_pkg::C4_WIN_LEN,
    parameter int unsigned CELL_W  = c4_pkg::C4_CELL_W
) (
    input  logic              CLOCK_50,
    input  logic              Resetn,
    input  logic              start,
    input  logic [2:0]        row,
    input  logic [2:0]        col,
    input  logic [CELL_W-1:0] player,
    output logic              rd_en,
    output logic [5:0]        rd_addr,
    input  logic [CELL_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              win
`ifdef WIN_SCAN_DRAW_EN
    ,
    output logic              draw
`endif
);

    localparam logic [3:0] ROWS4 = 4'(ROWS);
    localparam logic [3:0] COLS4 = 4'(COLS);
    localparam logic [3:0] WIN4  = 4'(WIN_LEN);

    state_e state_q, state_d;
    logic signed [3:0] pr_q, pr_d, pc_q, pc_d;
    logic signed [3:0] cr_q, cr_d, cc_q, cc_d;
    logic [CELL_W-1:0] player_q, player_d;
    logic [1:0] dir_q, dir_d;
    logic       bwd_q, bwd_d;
    logic [3:0] cnt_q, cnt_d;
    logic       win_q, win_d;
    logic       rd_en_q, rd_en_d;
    logic [5:0] rd_addr_q, rd_addr_d;
    logic       arm_end, end_bwd;

    logic signed [3:0] dr, dc;
    logic signed [3:0] fwd_r, fwd_c, bwd_r, bwd_c, stp_r, stp_c;
    logic              fwd_ok, bwd_ok, stp_ok;
    logic [5:0]        fwd_addr, bwd_addr, stp_addr;

    always_comb begin
        dr    = DIR_DR[dir_q];
        dc    = DIR_DC[dir_q];
        fwd_r = pr_q + dr;
        fwd_c = pc_q + dc;
        bwd_r = pr_q - dr;
        bwd_c = pc_q - dc;
        stp_r = bwd_q ? cr_q - dr : cr_q + dr;
        stp_c = bwd_q ? cc_q - dc : cc_q + dc;
    end

    win_scan_addr #(.ROWS(ROWS), .COLS(COLS)) u_fwd_addr (
        .r         (fwd_r),
        .c         (fwd_c),
        .in_bounds (fwd_ok),
        .addr      (fwd_addr)
    );

    win_scan_addr #(.ROWS(ROWS), .COLS(COLS)) u_bwd_addr (
        .r         (bwd_r),
        .c         (bwd_c),
        .in_bounds (bwd_ok),
        .addr      (bwd_addr)
    );

    win_scan_addr #(.ROWS(ROWS), .COLS(COLS)) u_stp_addr (
        .r         (stp_r),
        .c         (stp_c),
        .in_bounds (stp_ok),
        .addr      (stp_addr)
    );

    always_comb begin
        state_d   = state_q;
        pr_d      = pr_q;
        pc_d      = pc_q;
        cr_d      = cr_q;
        cc_d      = cc_q;
        player_d  = player_q;
        dir_d     = dir_q;
        bwd_d     = bwd_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        arm_end   = 1'b0;
        end_bwd   = bwd_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    pr_d     = {1'b0, row};
                    pc_d     = {1'b0, col};
                    player_d = player;
                    dir_d    = 2'd0;
                    win_d    = 1'b0;
                    if (player == '0 || {1'b0, row} >= ROWS4 || {1'b0, col} >= COLS4) begin
                        state_d = StDone;
                    end else begin
                        state_d = StDir;
                    end
                end
            end
            StDir: begin
                cnt_d = 4'd1;
                if (fwd_ok) begin
                    bwd_d     = 1'b0;
                    cr_d      = fwd_r;
                    cc_d      = fwd_c;
                    rd_en_d   = 1'b1;
                    rd_addr_d = fwd_addr;
                    state_d   = StRead;
                end else begin
                    arm_end = 1'b1;
                    end_bwd = 1'b0;
                end
            end
            StRead: state_d = StCmp;
            StCmp: begin
                if (rd_data == player_q) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == WIN4) begin
                        win_d   = 1'b1;
                        state_d = StDone;
                    end else if (stp_ok) begin
                        cr_d      = stp_r;
                        cc_d      = stp_c;
                        rd_en_d   = 1'b1;
                        rd_addr_d = stp_addr;
                        state_d   = StRead;
                    end else begin
                        arm_end = 1'b1;
                    end
                end else begin
                    arm_end = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A finished forward arm hands over to the backward arm; a finished
        // backward arm advances the direction.
        if (arm_end) begin
            if (!end_bwd && bwd_ok) begin
                bwd_d     = 1'b1;
                cr_d      = bwd_r;
                cc_d      = bwd_c;
                rd_en_d   = 1'b1;
                rd_addr_d = bwd_addr;
                state_d   = StRead;
            end else if (dir_q == 2'd3) begin
                state_d = StDone;
            end else begin
                dir_d   = dir_q + 2'd1;
                state_d = StDir;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= StIdle;
            pr_q      <= '0;
            pc_q      <= '0;
            cr_q      <= '0;
            cc_q      <= '0;
            player_q  <= '0;
            dir_q     <= '0;
            bwd_q     <= 1'b0;
            cnt_q     <= '0;
            win_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            pr_q      <= pr_d;
            pc_q      <= pc_d;
            cr_q      <= cr_d;
            cc_q      <= cc_d;
            player_q  <= player_d;
            dir_q     <= dir_d;
            bwd_q     <= bwd_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

`ifdef WIN_SCAN_DRAW_EN
    localparam logic [5:0] NCELLS = 6'(ROWS * COLS);

    logic [5:0] place_cnt_q, place_cnt_d;
    logic       draw_q, draw_d;

    always_comb begin
        place_cnt_d = place_cnt_q;
        draw_d      = draw_q;
        if (state_q == StIdle && start) begin
            draw_d = 1'b0;
            if (player != '0) begin
                place_cnt_d = place_cnt_q + 6'd1;
            end
        end
        if (state_d == StDone && state_q != StDone) begin
            draw_d = !win_d && (place_cnt_d == NCELLS);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            place_cnt_q <= '0;
            draw_q      <= 1'b0;
        end else begin
            place_cnt_q <= place_cnt_d;
            draw_q      <= draw_d;
        end
    end

    assign draw = draw_q;
`endif

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign win     = win_q;

endmodule

// File: tb/tb_win_scan_ctrl.sv
// Randomized and directed bench for win_scan_ctrl against a board-walk model;
// the draw checks are compiled in with WIN_SCAN_DRAW_EN.
module tb_win_scan_ctrl;

    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int WIN_LEN = 4;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn;
    logic       start;
    logic [2:0] row, col;
    logic [1:0] player;
    logic       rd_en;
    logic [5:0] rd_addr;
    logic [1:0] rd_data;
    logic       busy, done, win;
`ifdef WIN_SCAN_DRAW_EN
    logic       draw;
`endif

    win_scan_ctrl dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .start    (start),
        .row      (row),
        .col      (col),
        .player   (player),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .win      (win)
`ifdef WIN_SCAN_DRAW_EN
        ,
        .draw     (draw)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    logic [1:0] board [64];
    int obs_addrs[$];
    int exp_addrs[$];
    int n_checks = 0;
    int n_errors = 0;
    int model_cnt = 0;
    int drs[4] = '{0, 1, 1, 1};
    int dcs[4] = '{1, 0, 1, -1};

    // Board store: data valid one cycle after the strobe, junk otherwise.
    always @(posedge CLOCK_50) begin
        if (rd_en) begin
            rd_data <= board[rd_addr];
            obs_addrs.push_back(int'(rd_addr));
        end else begin
            rd_data <= 2'b11;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit in_b(input int r, input int c);
        return r >= 0 && r < ROWS && c >= 0 && c < COLS;
    endfunction

    task automatic model_scan(input int r, input int c, input int p,
                              output int w, output int lat);
        int d_cnt, cnt, rr, cc, sgn;
        bit stop;
        exp_addrs.delete();
        w = 0;
        d_cnt = 0;
        if (p != 0 && r < ROWS && c < COLS) begin
            for (int d = 0; d < 4 && w == 0; d++) begin
                d_cnt++;
                cnt = 1;
                for (int arm = 0; arm < 2 && w == 0; arm++) begin
                    sgn = (arm == 0) ? 1 : -1;
                    rr = r + sgn * drs[d];
                    cc = c + sgn * dcs[d];
                    stop = 0;
                    while (!stop && in_b(rr, cc)) begin
                        exp_addrs.push_back(rr * COLS + cc);
                        if (int'(board[rr * COLS + cc]) == p) begin
                            cnt++;
                            if (cnt == WIN_LEN) begin
                                w = 1;
                                stop = 1;
                            end
                            rr += sgn * drs[d];
                            cc += sgn * dcs[d];
                        end else begin
                            stop = 1;
                        end
                    end
                end
            end
        end
        lat = d_cnt + 2 * exp_addrs.size();
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 2'b00;
    endtask

    task automatic apply_reset();
        Resetn = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        Resetn = 1'b1;
        model_cnt = 0;
    endtask

    // One scan; extra >= 0 pulses start again that many cycles in.
    task automatic run_scan(input int r, input int c, input int p, input int extra,
                            output int obs_win, output int lat);
        int exp_win, exp_lat;
        model_scan(r, c, p, exp_win, exp_lat);
        if (p != 0) model_cnt++;
        obs_addrs.delete();
        @(negedge CLOCK_50);
        start = 1'b1;
        row = 3'(r);
        col = 3'(c);
        player = 2'(p);
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        lat = -1;
        for (int n = 0; n < 40 && lat < 0; n++) begin
            @(negedge CLOCK_50);
            if (done) lat = n;
            start = (n == extra);
        end
        start = 1'b0;
        obs_win = int'(win);
        check_val("latency", lat, exp_lat);
        check_val("win", obs_win, exp_win);
`ifdef WIN_SCAN_DRAW_EN
        check_val("draw", int'(draw), int'(model_cnt == ROWS * COLS && exp_win == 0));
`endif
        check_val("nreads", obs_addrs.size(), exp_addrs.size());
        for (int i = 0; i < obs_addrs.size() && i < exp_addrs.size(); i++)
            check_val("rd_addr", obs_addrs[i], exp_addrs[i]);
        @(negedge CLOCK_50);
        check_val("done_pulse", int'(done), 0);
        check_val("idle_busy", int'(busy), 0);
        check_val("win_hold", int'(win), exp_win);
    endtask

    int w, l;
    int t1_addrs[5] = '{39, 37, 31, 30, 32};

    initial begin
        Resetn = 1'b0;
        start = 1'b0;
        row = '0;
        col = '0;
        player = '0;
        clear_board();
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_win", int'(win), 0);
        check_val("rst_rd_en", int'(rd_en), 0);
        check_val("rst_rd_addr", int'(rd_addr), 0);
        Resetn = 1'b1;

        // Empty board, plus a start pulse while busy that must be dropped.
        run_scan(5, 3, 1, 3, w, l);
        check_val("t1_win", w, 0);
        check_val("t1_lat", l, 14);
        for (int i = 0; i < 5 && i < obs_addrs.size(); i++)
            check_val("t1_addr", obs_addrs[i], t1_addrs[i]);
        @(negedge CLOCK_50);
        check_val("no_queue", int'(busy), 0);

        // Horizontal run closed by the backward arm of d0.
        clear_board();
        for (int c = 0; c < 3; c++) board[5 * COLS + c] = 2'b01;
        run_scan(5, 3, 1, -1, w, l);
        check_val("t2_win", w, 1);
        check_val("t2_lat", l, 9);
        check_val("t2_nreads", obs_addrs.size(), 4);

        // Vertical run found on the forward arm of d1.
        clear_board();
        for (int r = 3; r < 6; r++) board[r * COLS + 2] = 2'b10;
        run_scan(2, 2, 2, -1, w, l);
        check_val("t3_win", w, 1);
        check_val("t3_lat", l, 12);
        if (obs_addrs.size() == 5) begin
            check_val("t3_a2", obs_addrs[2], 23);
            check_val("t3_a3", obs_addrs[3], 30);
            check_val("t3_a4", obs_addrs[4], 37);
        end else begin
            check_val("t3_nreads", obs_addrs.size(), 5);
        end

        // Anti-diagonal straddling both arms, for the owner and the opponent.
        clear_board();
        board[2 * COLS + 3] = 2'b01;
        board[3 * COLS + 2] = 2'b01;
        board[4 * COLS + 1] = 2'b01;
        board[5 * COLS + 0] = 2'b01;
        run_scan(3, 2, 1, -1, w, l);
        check_val("t4_win", w, 1);
        check_val("t4_lat", l, 22);
        run_scan(3, 2, 2, -1, w, l);
        check_val("t4b_win", w, 0);
        check_val("t4b_lat", l, 20);

        // Asynchronous reset in the middle of a scan.
        clear_board();
        @(negedge CLOCK_50);
        start = 1'b1;
        row = 3'd5;
        col = 3'd3;
        player = 2'd1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        repeat (4) @(posedge CLOCK_50);
        #2 Resetn = 1'b0;
        #1;
        check_val("mid_rst_busy", int'(busy), 0);
        check_val("mid_rst_rd_en", int'(rd_en), 0);
        check_val("mid_rst_win", int'(win), 0);
        @(negedge CLOCK_50);
        Resetn = 1'b1;
        model_cnt = 0;
        run_scan(5, 3, 1, -1, w, l);
        check_val("post_rst_lat", l, 14);

        // Random boards biased towards player 1; includes invalid starts.
        for (int it = 0; it < 150; it++) begin
            for (int i = 0; i < ROWS * COLS; i++) begin
                int v;
                v = $urandom_range(0, 3);
                board[i] = (v == 3) ? 2'b01 : 2'(v);
            end
            run_scan($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2), -1, w, l);
        end

`ifdef WIN_SCAN_DRAW_EN
        apply_reset();
        clear_board();
        for (int i = 0; i < ROWS * COLS; i++) begin
            run_scan(i / COLS, i % COLS, 1 + (i % 2), -1, w, l);
        end
        check_val("draw_last", int'(draw), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
